wr_enable_arbiter: RTL and testbench
====================================

# wr_enable_arbiter

Round-robin write-enable arbiter that sits directly upstream of the 4-bit, 16-enable output register. Up to N requesters each present a WIDTH-bit word with a request strobe. Each cycle the arbiter picks at most one requester, drives a registered one-hot enable vector that maps bit k to the register's enable k+1, and drives the matching data word. The downstream register therefore never sees two enables at once.

## Interface
- WIDTH, 4, data word width; matches the downstream register.
- N, 16, number of requesters / enable lines.
- clk  in  1  rising-edge clock for all state.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- req  in  N  request strobes; bit k for requester k.
- req_data  in  N*WIDTH  packed words; requester k occupies bits [k*WIDTH +: WIDTH].
- hold  in  1  freezes arbitration; no grant is issued while high.
- en  out  N  registered one-hot enable; bit k drives downstream enable k+1. All zero means no write.
- d_out  out  WIDTH  registered data word for the downstream register's data input.
- ack  out  N  registered one-hot acknowledge; equals en every cycle.
- grant_idx  out  log2(N)  index of the last granted requester; holds between grants.

## Operation
- State:
  - ptr (log2(N) bits), the highest-priority requester for the next decision.
  - Registered outputs.
  - There is no other FSM. The block has two effective modes: IDLE (en==0) and GRANT (en one-hot).
- Decision at each rising edge, when rst==0, hold==0 and req!=0:
  - Choose the winner i: the first set bit of req scanning circularly ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - en <= one-hot(i); ack <= one-hot(i).
  - d_out <= req_data[i*WIDTH +: WIDTH].
  - grant_idx <= i.
  - ptr <= (i+1) mod N. Wrap from N-1 to 0 is required.
- req==0 or hold==1:
  - en <= 0, ack <= 0.
  - d_out, grant_idx and ptr hold their values.
- Requester protocol:
  - A requester keeps req[k] high until it sees ack[k].
  - If req[k] is still high on the edge where ack[k] is visible, that is a new request, and the held word is written again.
  - Requester k is at lowest priority immediately after its own grant.
- Fairness: a continuously requesting requester is granted within N consecutive grant cycles, counting from when its request is first sampled.
- Invariants:
  - en and ack are always zero or one-hot; popcount(en) ≤ 1 every cycle.
  - d_out changes only on cycles that produce a grant.
- Reset: en=0, ack=0, d_out=0, grant_idx=0, ptr=0. Reset takes priority over hold and req. Reset in the middle of a grant clears en/ack on that edge, and the pending request is not acknowledged.

## Timing
- Latency: a request sampled at edge t produces en/ack/d_out valid after edge t, during cycle t+1. The downstream register captures d_out at edge t+1.
- Throughput: one grant per cycle. Back-to-back grants to different requesters are allowed with no bubble.
- hold is sampled on the same edge as req. Raising hold at edge t suppresses a grant at t. A grant already on en from edge t-1 completes normally.
- All outputs are registers. There is no combinational path from req, req_data or hold to any output.
- req_data is sampled only on the deciding edge. Later changes do not affect d_out.

## Test plan
- Reset: assert rst for 2 cycles while req=16'hFFFF -> en=0, ack=0, d_out=0, grant_idx=0 on both cycles. After release, the first grant goes to requester 0.
- Single requester: req=16'h0020, word5=4'hA for 1 cycle -> next cycle en=16'h0020, ack=16'h0020, d_out=4'hA, grant_idx=5. The following cycle en=0 and d_out stays 4'hA.
- Round-robin with wrap: req=16'h8001 held with ptr=0 -> grants alternate 0, 15, 0, 15 with no idle cycle, and en is one-hot every cycle.
- Full contention: req=16'hFFFF for 16 cycles from reset -> grant_idx sequence 0,1,…,15. Each requester receives exactly one ack, and d_out tracks each word.
- hold: req=16'h0004 with hold=1 for 3 cycles, then hold=0 -> no en during the hold cycles. The grant to requester 2 appears the cycle after hold drops.
- Reset mid-traffic: rst=1 on the edge after a grant to requester 7 is issued (with requests still pending) -> en=0 and ptr=0 on the next cycle. After release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/wr_enable_arbiter.sv
// Round-robin write-enable arbiter: grants at most one requester per cycle and
// drives a registered one-hot enable plus the winning data word downstream.
module wr_enable_arbiter #(
    parameter int WIDTH = 4,
    parameter int N     = 16,
    parameter int IDXW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   req_data,
    input  logic                 hold,
    output logic [N-1:0]         en,
    output logic [WIDTH-1:0]     d_out,
    output logic [N-1:0]         ack,
    output logic [IDXW-1:0]      grant_idx
);

    logic [IDXW-1:0]  ptr_q, ptr_d;
    logic [N-1:0]     en_q, en_d;
    logic [WIDTH-1:0] d_out_q, d_out_d;
    logic [IDXW-1:0]  grant_idx_q, grant_idx_d;

    logic             found;
    logic [IDXW-1:0]  winner;

    // Circular scan starting at ptr; the first hit wins.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int off = 0; off < N; off++) begin
            int j;
            j = int'(ptr_q) + off;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req[j]) begin
                found  = 1'b1;
                winner = IDXW'(j);
            end
        end
    end

    always_comb begin
        en_d        = '0;
        d_out_d     = d_out_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        if (!hold && found) begin
            en_d        = N'(1) << winner;
            d_out_d     = req_data[int'(winner)*WIDTH +: WIDTH];
            grant_idx_d = winner;
            // The winner drops to lowest priority for the next decision.
            if (winner == IDXW'(N-1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = winner + IDXW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            en_q        <= '0;
            d_out_q     <= '0;
            grant_idx_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            en_q        <= en_d;
            d_out_q     <= d_out_d;
            grant_idx_q <= grant_idx_d;
        end
    end

    assign en        = en_q;
    assign ack       = en_q;
    assign d_out     = d_out_q;
    assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_wr_enable_arbiter.sv
// Self-checking bench for wr_enable_arbiter: per-cycle scoreboard against a
// rotate-and-find reference model, plus directed checks of the key scenarios.
module tb_wr_enable_arbiter;

    localparam int WIDTH = 4;
    localparam int N     = 16;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*WIDTH-1:0] req_data;
    logic            hold;
    logic [N-1:0]    en;
    logic [WIDTH-1:0] d_out;
    logic [N-1:0]    ack;
    logic [3:0]      grant_idx;

    typedef struct {
        logic [15:0] en;
        logic [3:0]  d;
        logic [3:0]  gi;
    } exp_t;

    exp_t q[$];
    int   passed = 0;
    int   total  = 0;

    int          m_ptr;
    logic [3:0]  m_d;
    logic [3:0]  m_gi;
    logic [15:0] ack_seen;

    wr_enable_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .hold(hold),
        .en(en), .d_out(d_out), .ack(ack), .grant_idx(grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: rotate req so ptr lands at bit 0, take the lowest set bit.
    task automatic model_step(input logic r, input logic [15:0] rq, input logic h, output exp_t e);
        logic [31:0] dbl;
        logic [15:0] rot;
        int k;
        e.en = '0;
        if (r) begin
            m_ptr = 0; m_d = '0; m_gi = '0;
        end else if (!h && rq != 0) begin
            dbl = {rq, rq} >> m_ptr;
            rot = dbl[15:0];
            k = 0;
            while (!rot[k]) k++;
            k = (k + m_ptr) % 16;
            e.en  = 16'h1 << k;
            m_d   = req_data[k*WIDTH +: WIDTH];
            m_gi  = 4'(k);
            m_ptr = (k + 1) % 16;
        end
        e.d  = m_d;
        e.gi = m_gi;
    endtask

    task automatic cyc(input logic r, input logic [15:0] rq, input logic h);
        exp_t e;
        @(negedge clk);
        rst = r; req = rq; hold = h;
        model_step(r, rq, h, e);
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("sb_en", 32'(en), 32'(e.en));
        chk("sb_ack", 32'(ack), 32'(e.en));
        chk("sb_d_out", 32'(d_out), 32'(e.d));
        chk("sb_grant_idx", 32'(grant_idx), 32'(e.gi));
        chk("onehot", 32'($countones(en) <= 1), 32'(1));
        ack_seen = ack_seen | ack;
    endtask

    initial begin
        rst = 1'b1; req = '0; hold = 1'b0;
        m_ptr = 0; m_d = '0; m_gi = '0; ack_seen = '0;
        for (int k = 0; k < N; k++) req_data[k*WIDTH +: WIDTH] = 4'(15 - k);

        // Reset with all requests asserted
        for (int c = 0; c < 2; c++) begin
            cyc(1'b1, 16'hFFFF, 1'b0);
            chk("rst_en", 32'(en), 32'h0);
            chk("rst_d_out", 32'(d_out), 32'h0);
            chk("rst_gi", 32'(grant_idx), 32'h0);
        end

        // Full contention: 0..15 in order, each acked once
        ack_seen = '0;
        for (int c = 0; c < 16; c++) begin
            cyc(1'b0, 16'hFFFF, 1'b0);
            chk("full_gi", 32'(grant_idx), 32'(c));
            chk("full_d_out", 32'(d_out), 32'(15 - c));
        end
        chk("full_all_acked", 32'(ack_seen), 32'hFFFF);

        // Single requester 5 with word A, then idle
        req_data[5*WIDTH +: WIDTH] = 4'hA;
        cyc(1'b0, 16'h0020, 1'b0);
        chk("single_en", 32'(en), 32'h0020);
        chk("single_ack", 32'(ack), 32'h0020);
        chk("single_d_out", 32'(d_out), 32'hA);
        chk("single_gi", 32'(grant_idx), 32'd5);
        req_data[5*WIDTH +: WIDTH] = 4'h3;
        cyc(1'b0, 16'h0000, 1'b0);
        chk("single_idle_en", 32'(en), 32'h0);
        chk("single_idle_d_out", 32'(d_out), 32'hA);

        // Wrap between 0 and 15 from ptr=0
        cyc(1'b1, 16'h0000, 1'b0);
        for (int c = 0; c < 4; c++) begin
            cyc(1'b0, 16'h8001, 1'b0);
            chk("wrap_gi", 32'(grant_idx), (c % 2 == 0) ? 32'd0 : 32'd15);
            chk("wrap_en", 32'(en), (c % 2 == 0) ? 32'h0001 : 32'h8000);
        end

        // hold suppresses grants, grant follows release
        for (int c = 0; c < 3; c++) begin
            cyc(1'b0, 16'h0004, 1'b1);
            chk("hold_en", 32'(en), 32'h0);
        end
        cyc(1'b0, 16'h0004, 1'b0);
        chk("hold_release_en", 32'(en), 32'h0004);
        chk("hold_release_gi", 32'(grant_idx), 32'd2);

        // Reset right after a grant to 7, with 7 and 8 still pending
        cyc(1'b0, 16'h0180, 1'b0);
        chk("mid_gi7", 32'(grant_idx), 32'd7);
        cyc(1'b1, 16'h0180, 1'b0);
        chk("mid_rst_en", 32'(en), 32'h0);
        chk("mid_rst_gi", 32'(grant_idx), 32'h0);
        cyc(1'b0, 16'h0181, 1'b0);
        chk("mid_restart_gi", 32'(grant_idx), 32'd0);
        chk("mid_restart_en", 32'(en), 32'h0001);

        // Random traffic against the reference model
        for (int c = 0; c < 200; c++) begin
            for (int k = 0; k < N; k++) req_data[k*WIDTH +: WIDTH] = 4'($urandom_range(0, 15));
            cyc(($urandom_range(0, 49) == 0), 16'($urandom), ($urandom_range(0, 5) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
